// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and default geometry for seq_chunk_adder.
package adder_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit adder with carry in/out, one chunk per cycle.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder processing CHUNK bits per cycle, LSB chunk first.
// Define SEQ_CHUNK_ADDER_OVERFLOW_EN to add the signed-overflow output overflow_out.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
    ,
    output logic             overflow_out
`endif
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_geometry
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t             state;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a_r, b_r, acc, acc_nx;
    logic               c_r, c_c;
    logic [CHUNK-1:0]   s_c;

    chunk_adder #(.W(CHUNK)) u_chunk (
        .a    (a_r[int'(k)*CHUNK +: CHUNK]),
        .b    (b_r[int'(k)*CHUNK +: CHUNK]),
        .cin  (c_r),
        .sum  (s_c),
        .cout (c_c)
    );

    // Accumulator with this cycle's chunk already merged, so DONE entry can load it directly.
    always_comb begin
        acc_nx = acc;
        acc_nx[int'(k)*CHUNK +: CHUNK] = s_c;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= IDLE;
            k         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            acc       <= '0;
            ready_out <= 1'b0;
            valid_out <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
            overflow_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready_out <= 1'b1;
                    if (valid_in && ready_out) begin
                        a_r       <= a_in;
                        b_r       <= b_in;
                        c_r       <= carry_in;
                        k         <= '0;
                        acc       <= '0;
                        ready_out <= 1'b0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    acc <= acc_nx;
                    c_r <= c_c;
                    k   <= k + 1'b1;
                    if (k == KW'(N - 1)) begin
                        state     <= DONE;
                        sum_out   <= acc_nx;
                        carry_out <= c_c;
                        valid_out <= 1'b1;
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
                        overflow_out <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_nx[WIDTH-1] != a_r[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed + random checks of seq_chunk_adder at CHUNK = 4, 16 and 1.
module tb_seq_chunk_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         cin;
    logic         vin  [3];
    logic         rin  [3];
    logic         rdy  [3];
    logic         vout [3];
    logic         cout [3];
    logic [W-1:0] sum  [3];
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
    logic         ovf  [3];
`endif
    int checks = 0;
    int errors = 0;
    int lat [3] = '{4, 1, 16};

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u4 (
        .clk_in(clk), .reset_n_in(rst_n), .valid_in(vin[0]), .ready_out(rdy[0]),
        .a_in(a), .b_in(b), .carry_in(cin), .valid_out(vout[0]), .ready_in(rin[0]),
        .sum_out(sum[0]), .carry_out(cout[0])
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
        , .overflow_out(ovf[0])
`endif
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u16 (
        .clk_in(clk), .reset_n_in(rst_n), .valid_in(vin[1]), .ready_out(rdy[1]),
        .a_in(a), .b_in(b), .carry_in(cin), .valid_out(vout[1]), .ready_in(rin[1]),
        .sum_out(sum[1]), .carry_out(cout[1])
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
        , .overflow_out(ovf[1])
`endif
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u1 (
        .clk_in(clk), .reset_n_in(rst_n), .valid_in(vin[2]), .ready_out(rdy[2]),
        .a_in(a), .b_in(b), .carry_in(cin), .valid_out(vout[2]), .ready_in(rin[2]),
        .sum_out(sum[2]), .carry_out(cout[2])
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
        , .overflow_out(ovf[2])
`endif
    );

    task automatic chk(input int i, input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL u%0d %s got=%0h exp=%0h", i, tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int i, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int stall);
        logic [W:0]   r;
        logic         r_ovf;
        logic [W-1:0] hs;
        logic         hc;
        int           s;
        r     = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        s     = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        r_ovf = (s > 32767) || (s < -32768);
        chk(i, "ready_before_accept", rdy[i], 1);
        a = ta; b = tb; cin = tc;
        vin[i] = 1'b1;
        rin[i] = (stall == 0);
        step();
        vin[i] = 1'b0;
        for (int n = 1; n <= lat[i]; n++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            vin[i] = 1'($urandom);
            step();
            chk(i, "ready_busy", rdy[i], 0);
            chk(i, (n < lat[i]) ? "valid_early" : "valid_latency", vout[i], (n == lat[i]));
        end
        vin[i] = 1'b0;
        chk(i, "sum", sum[i], r[W-1:0]);
        chk(i, "carry", cout[i], r[W]);
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
        chk(i, "overflow", ovf[i], r_ovf);
`endif
        hs = sum[i];
        hc = cout[i];
        for (int t = 0; t < stall; t++) begin
            vin[i] = 1'b1;
            a = W'($urandom); b = W'($urandom);
            step();
            chk(i, "stall_valid", vout[i], 1);
            chk(i, "stall_sum", sum[i], r[W-1:0]);
            chk(i, "stall_carry", cout[i], r[W]);
            chk(i, "stall_ready", rdy[i], 0);
        end
        vin[i] = 1'b0;
        rin[i] = 1'b1;
        if (stall > 0) step();
        step();
        chk(i, "valid_after_hs", vout[i], 0);
        chk(i, "ready_after_hs", rdy[i], 1);
        chk(i, "sum_retained", sum[i], hs);
        chk(i, "carry_retained", cout[i], hc);
    endtask

    task automatic rst_mid(input int i);
        chk(i, "ready_before_abort", rdy[i], 1);
        a = 16'h4321; b = 16'h1111; cin = 1'b0;
        vin[i] = 1'b1;
        step();
        vin[i] = 1'b0;
        if (lat[i] >= 2) step();
        rst_n = 1'b0;
        #1;
        chk(i, "rst_ready", rdy[i], 0);
        chk(i, "rst_valid", vout[i], 0);
        chk(i, "rst_sum", sum[i], 0);
        chk(i, "rst_carry", cout[i], 0);
        step();
        rst_n = 1'b1;
        step();
        chk(i, "ready_after_rst", rdy[i], 1);
        for (int n = 0; n < lat[i] + 3; n++) begin
            step();
            chk(i, "no_aborted_result", vout[i], 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            rin[i] = 1'b1;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk(i, "reset_ready", rdy[i], 0);
            chk(i, "reset_valid", vout[i], 0);
            chk(i, "reset_sum", sum[i], 0);
            chk(i, "reset_carry", cout[i], 0);
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
            chk(i, "reset_overflow", ovf[i], 0);
`endif
        end
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            txn(i, 16'h0000, 16'h0000, 1'b0, 0);
            txn(i, 16'h000F, 16'h000D, 1'b1, 0);
            txn(i, 16'hFFFF, 16'h0001, 1'b0, 0);
            txn(i, 16'h7FFF, 16'h0001, 1'b0, 0);
            txn(i, 16'h8000, 16'h8000, 1'b0, 0);
            txn(i, 16'h1234, 16'h5678, 1'b1, 3);
            for (int r = 0; r < 8; r++)
                txn(i, W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            txn(i, 16'h1111, 16'h2222, 1'b0, 0);
            rst_mid(i);
            txn(i, W'($urandom), W'($urandom), 1'($urandom), 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
